// File: rtl/ifetch_unit.sv
// ifetch_unit
// Instruction fetch stage. Issues one word-aligned fetch at a time to
// instruction memory, captures the returned word in an instruction register
// and holds it until downstream retires it. Then it computes the next fetch
// address: a jump, a taken branch, or sequential.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous active-high reset
//   imem_req     fetch request (high only while fetching)
//   imem_addr    fetch address, always equal to pc
//   imem_ack     memory returns data this cycle (only honoured while fetching)
//   imem_rdata   returned instruction word
//   instr        instruction register
//   pc           address of the word held in instr
//   pcplus4      pc + 4 (mod 2^32)
//   instr_valid  instr holds an instruction waiting to retire
//   instr_ready  downstream retires the held instruction this cycle
//   branch       decoder branch control for the held instruction
//   jump         decoder jump control for the held instruction
//   zero         ALU zero flag for the held instruction
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero
);

  // Fetch addresses are always word aligned, whatever the parameter says.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] pcplus4_r;
  logic [31:0] instr_r;
  logic        instr_valid_r;
  logic        imem_req_r;
  logic [31:0] next_pc_s;

  // Branch displacement: sign-extended word offset, scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  // Jump target: keeps the 256 MB region of the sequential address.
  function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                              input logic [25:0] index);
    return {region, index, 2'b00};
  endfunction

  // Next-pc select; jump outranks a taken branch. Carries out of bit 31 are dropped.
  always_comb begin
    next_pc_s = pcplus4_r;
    if (jump) begin
      next_pc_s = jump_target(pcplus4_r[31:28], instr_r[25:0]);
    end else if (branch && zero) begin
      next_pc_s = pcplus4_r + branch_offset(instr_r[15:0]);
    end else begin
      next_pc_s = pcplus4_r;
    end
  end

  // Fetch sequencer: owns state, pc, instruction register and handshake outputs.
  // pcplus4 is kept as its own register, updated together with pc.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC_ALIGNED;
      pcplus4_r     <= RESET_PC_ALIGNED + 32'd4;
      instr_r       <= 32'h00000000;
      instr_valid_r <= 1'b0;
      imem_req_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r       <= FETCH;
          imem_req_r    <= 1'b1;
          instr_valid_r <= 1'b0;
        end
        FETCH: begin
          if (imem_ack) begin
            instr_r       <= imem_rdata;
            state_r       <= HOLD;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b1;
          end else begin
            imem_req_r    <= 1'b1;
            instr_valid_r <= 1'b0;
          end
        end
        HOLD: begin
          // branch/jump/zero only matter on this retiring edge
          if (instr_ready) begin
            pc_r          <= next_pc_s;
            pcplus4_r     <= next_pc_s + 32'd4;
            state_r       <= FETCH;
            imem_req_r    <= 1'b1;
            instr_valid_r <= 1'b0;
          end else begin
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r       <= IDLE;
          imem_req_r    <= 1'b0;
          instr_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign pcplus4     = pcplus4_r;
  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit
// Self-checking bench for ifetch_unit: a directed vector table (including
// stalls, wait states, branch/jump/wrap corners), randomized retirements
// against an arithmetic next-pc model, and reset in FETCH and HOLD.
module tb_ifetch_unit;

  localparam logic [31:0] RST_PC = 32'h00000000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch;
  logic        jump;
  logic        zero;

  int          n_chk;
  int          n_fail;
  logic [31:0] cur_pc;
  string       ctx;

  typedef struct {
    logic [31:0] word;
    logic        br;
    logic        jp;
    logic        zr;
    int          ackd;
    int          rdyd;
    logic [31:0] exp_next;
  } vec_t;

  vec_t tbl [20];

  ifetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pc          (pc),
    .pcplus4     (pcplus4),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .branch      (branch),
    .jump        (jump),
    .zero        (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Next fetch address from the architectural rules, in plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                             input logic b, input logic j, input logic z);
    logic [31:0] seq;
    logic [15:0] imm;
    int          off;
    seq = p + 32'd4;
    if (j) return (seq & 32'hF0000000) | ((w & 32'h03FFFFFF) << 2);
    if (b && z) begin
      imm = w[15:0];
      off = int'($signed(imm));
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%s]: got %h, expected %h", name, ctx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ctrl();
    branch   = 1'($urandom_range(0, 1));
    jump     = 1'($urandom_range(0, 1));
    zero     = 1'($urandom_range(0, 1));
    imem_ack = 1'($urandom_range(0, 1));
  endtask

  task automatic release_reset();
    imem_ack = 1'b0;
    reset    = 1'b0;
    #1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    step();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RST_PC);
    cur_pc = RST_PC;
  endtask

  // One fetch/hold/retire transaction; called at #1 after a rising edge.
  task automatic run_instr(input logic [31:0] w, input logic b, input logic j, input logic z,
                           input int ackd, input int rdyd, input logic [31:0] exp_next);
    int guard;
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    guard = 0;
    while (imem_req !== 1'b1 && guard < 8) begin
      step();
      guard++;
    end
    chk("req_wait", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, cur_pc);
    chk("pc", pc, cur_pc);
    chk("pcplus4", pcplus4, cur_pc + 32'd4);
    chk("fetch_valid", {31'd0, instr_valid}, 32'd0);
    for (int k = 0; k < ackd; k++) begin
      step();
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, cur_pc);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = w;
    step();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    chk("instr", instr, w);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    for (int k = 0; k < rdyd; k++) begin
      rand_ctrl();
      step();
      chk("stall_pc", pc, cur_pc);
      chk("stall_instr", instr, w);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    branch      = b;
    jump        = j;
    zero        = z;
    instr_ready = 1'b1;
    imem_ack    = 1'($urandom_range(0, 1));
    step();
    instr_ready = 1'b0;
    rand_ctrl();
    imem_ack    = 1'b0;
    chk("next_addr", imem_addr, exp_next);
    chk("next_req", {31'd0, imem_req}, 32'd1);
    chk("next_valid", {31'd0, instr_valid}, 32'd0);
    cur_pc = exp_next;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic        b, j, z;

    n_chk = 0;
    n_fail = 0;
    cur_pc = RST_PC;
    ctx = "reset";

    //          word          br    jp    zr    ack rdy  next
    tbl[0]  = '{32'h20080005, 1'b0, 1'b0, 1'b0, 0,  0,   32'h00000004};
    tbl[1]  = '{32'h08000004, 1'b0, 1'b1, 1'b0, 3,  0,   32'h00000010};
    tbl[2]  = '{32'h1109FFFE, 1'b1, 1'b0, 1'b1, 0,  2,   32'h0000000C};
    tbl[3]  = '{32'h1000FFFC, 1'b1, 1'b0, 1'b1, 1,  1,   32'h00000000};
    tbl[4]  = '{32'h1000FFFE, 1'b1, 1'b0, 1'b1, 0,  0,   32'hFFFFFFFC};
    tbl[5]  = '{32'h20080005, 1'b0, 1'b0, 1'b1, 0,  0,   32'h00000000};
    tbl[6]  = '{32'h1000FFFE, 1'b1, 1'b0, 1'b0, 0,  1,   32'h00000004};
    tbl[7]  = '{32'h0BFFFFFF, 1'b0, 1'b1, 1'b0, 0,  0,   32'h0FFFFFFC};
    tbl[8]  = '{32'h00000000, 1'b0, 1'b0, 1'b0, 0,  0,   32'h10000000};
    tbl[9]  = '{32'h0BFFFFFF, 1'b0, 1'b1, 1'b0, 0,  0,   32'h1FFFFFFC};
    tbl[10] = '{32'h00000000, 1'b0, 1'b0, 1'b0, 0,  0,   32'h20000000};
    tbl[11] = '{32'h0BFFFFFF, 1'b0, 1'b1, 1'b0, 0,  0,   32'h2FFFFFFC};
    tbl[12] = '{32'h00000000, 1'b0, 1'b0, 1'b0, 0,  0,   32'h30000000};
    tbl[13] = '{32'h0BFFFFFF, 1'b0, 1'b1, 1'b0, 0,  0,   32'h3FFFFFFC};
    tbl[14] = '{32'h00000000, 1'b0, 1'b0, 1'b0, 0,  0,   32'h40000000};
    tbl[15] = '{32'h08000004, 1'b0, 1'b1, 1'b0, 0,  0,   32'h40000010};
    tbl[16] = '{32'h08000004, 1'b1, 1'b1, 1'b1, 0,  0,   32'h40000010};
    tbl[17] = '{32'h00007FFF, 1'b1, 1'b0, 1'b1, 2,  0,   32'h40020010};
    tbl[18] = '{32'h1109FFFE, 1'b0, 1'b0, 1'b1, 0,  0,   32'h40020014};
    tbl[19] = '{32'h1109FFFE, 1'b1, 1'b1, 1'b0, 0,  1,   32'h4427FFF8};

    reset       = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h00000000;
    instr_ready = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    zero        = 1'b0;
    repeat (3) step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_instr", instr, 32'h00000000);
    chk("rst_pcplus4", pcplus4, RST_PC + 32'd4);
    release_reset();

    for (int i = 0; i < 20; i++) begin
      ctx = $sformatf("vec%0d", i);
      run_instr(tbl[i].word, tbl[i].br, tbl[i].jp, tbl[i].zr,
                tbl[i].ackd, tbl[i].rdyd, tbl[i].exp_next);
    end

    for (int i = 0; i < 150; i++) begin
      ctx = $sformatf("rand%0d", i);
      w = $urandom;
      b = 1'($urandom_range(0, 1));
      j = 1'($urandom_range(0, 3) == 0);
      z = 1'($urandom_range(0, 1));
      run_instr(w, b, j, z, $urandom_range(0, 3), $urandom_range(0, 3),
                model_next(cur_pc, w, b, j, z));
    end

    // Reset while holding an instruction: valid drops at once, word is lost.
    ctx = "rst_hold";
    imem_ack   = 1'b1;
    imem_rdata = 32'h12345678;
    step();
    imem_ack   = 1'b0;
    chk("pre_valid", {31'd0, instr_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", {31'd0, instr_valid}, 32'd0);
    chk("async_instr", instr, 32'h00000000);
    chk("async_pc", pc, RST_PC);
    step();
    release_reset();

    // Reset while fetching from a non-reset address; ack during reset is dropped.
    ctx = "rst_fetch";
    run_instr(32'h00000000, 1'b0, 1'b0, 1'b0, 0, 0, 32'h00000004);
    chk("pre_req", {31'd0, imem_req}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_req", {31'd0, imem_req}, 32'd0);
    chk("async_pc", pc, RST_PC);
    chk("async_addr", imem_addr, RST_PC);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    step();
    step();
    chk("ack_in_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("ack_in_rst_instr", instr, 32'h00000000);
    release_reset();
    run_instr(32'h20080005, 1'b0, 1'b0, 1'b0, 0, 0, 32'h00000004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the address of the first fetch after reset; bits [1:0] are forced to 0.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port imem_req, output, 1, fetch request to instruction memory.
REQ-005 SHALL have port imem_addr, output, 32, fetch address; always equal to pc.
REQ-006 SHALL have port imem_ack, input, 1, memory has returned data this cycle.
REQ-007 SHALL have port imem_rdata, input, 32, fetched word; valid only when imem_ack=1.
REQ-008 SHALL have port instr, output, 32, instruction register; instr[31:26] drives the main decoder op field.
REQ-009 SHALL have port pc, output, 32, address of the instruction held in instr.
REQ-010 SHALL have port pcplus4, output, 32, pc+4 modulo 2^32.
REQ-011 SHALL have port instr_valid, output, 1, instr holds a fetched instruction awaiting retirement.
REQ-012 SHALL have port instr_ready, input, 1, downstream retires the current instruction this cycle.
REQ-013 SHALL have ports branch, jump, zero, each input, 1, the decoder branch and jump controls and the ALU zero flag for the current instruction.

Function
REQ-014 SHALL implement the FSM states IDLE, FETCH and HOLD.
REQ-015 SHALL transition IDLE->FETCH unconditionally on the first clock edge after reset deasserts.
REQ-016 SHALL, in FETCH, assert imem_req=1 and hold imem_addr stable until imem_ack=1.
REQ-017 SHALL, on the FETCH edge with imem_ack=1, load instr<=imem_rdata and go to HOLD.
REQ-018 SHALL hold instr_valid=1 exactly while in HOLD.
REQ-019 SHALL keep imem_req=0 in IDLE and HOLD, and ignore imem_ack outside FETCH.
REQ-020 SHALL, in HOLD with instr_ready=0, hold instr, pc and state unchanged.
REQ-021 SHALL, on a HOLD edge with instr_ready=1, update pc to next_pc and go to FETCH.
REQ-022 SHALL select next_pc by priority as follows.
- jump=1: {pcplus4[31:28], instr[25:0], 2'b00}.
- else branch&zero: pcplus4 + (signext(instr[15:0]) << 2).
- else: pcplus4.
REQ-023 SHALL sample branch, jump and zero only on the retiring edge; values on other edges have no effect.
REQ-024 SHALL give jump priority when branch=1, zero=1 and jump=1 together.
REQ-025 SHALL perform all address arithmetic in 32 bits and discard the carry, so pc=32'hFFFFFFFC sequential gives 32'h00000000.
REQ-026 SHALL wrap the branch target modulo 2^32 in both directions.
REQ-027 SHALL have a minimum latency of 1 cycle from an acked request to instr_valid=1.
REQ-028 SHALL reach peak throughput of one instruction per 2 cycles, with a zero-wait memory and instr_ready held high.
REQ-029 SHALL keep pc[1:0]=2'b00 at all times.

Reset
REQ-030 SHALL, while reset=1, asynchronously force state=IDLE, pc=RESET_PC, instr=32'h00000000, instr_valid=0 and imem_req=0.
REQ-031 SHALL, on reset asserted mid-FETCH, drop imem_req in the same cycle and discard any ack that arrives during reset.
REQ-032 SHALL, on reset asserted in HOLD, clear instr_valid immediately; the pending instruction is lost.
REQ-033 SHALL issue the first request after reset release to RESET_PC.

Verification
REQ-034 SHALL cover reset release: imem_req=0 in cycle 1, then =1 with imem_addr=0; ack with rdata=32'h20080005 -> instr=32'h20080005 and instr_valid=1 next cycle.
REQ-035 SHALL cover a wait-state memory: ack delayed 3 cycles -> imem_req and imem_addr held for 4 cycles, instr_valid=0 throughout.
REQ-036 SHALL cover a backpressured taken branch: pc=32'h00000010, instr=32'h1109FFFE (BEQ), branch=1, zero=1, instr_ready=0 for 2 cycles then 1 -> pc unchanged for 2 cycles, then next fetch address 32'h0000000C.
REQ-037 SHALL cover a jump: pc=32'h40000000, instr=32'h08000004, jump=1, instr_ready=1 -> next imem_addr=32'h40000010; with branch=zero=1 also set, still 32'h40000010.
REQ-038 SHALL cover wrap: pc=32'hFFFFFFFC, branch=0, jump=0, retire -> next imem_addr=32'h00000000.
REQ-039 SHALL cover reset mid-FETCH: assert reset with imem_req=1 -> imem_req=0 and pc=RESET_PC the same cycle; an ack arriving during reset leaves instr_valid=0.
